// File: rtl/dp_mem_port_arbiter.sv
// dp_mem_port_arbiter: round-robin, burst-limited sharing of one single-port RAM between ports A and B.
// Define DP_ARB_STATS_EN to add saturating grant/conflict counters.
module dp_mem_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_a,
  input  logic              valid_b,
  output logic              ready_a,
  output logic              ready_b,
  input  logic              op_a,
  input  logic              op_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DP_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt_a,
  output logic [15:0]       grant_cnt_b,
  output logic [15:0]       conflict_cnt
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t            state;
  logic [CW-1:0]     burst_cnt;
  logic              rr_last;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_b;
  logic              below;
  logic              gnt_a;
  logic              gnt_b;
  logic              gnt;
  logic              stay;
  assign below = burst_cnt < CW'(MAX_BURST);
  // The current owner keeps the grant against contention only while below the burst limit.
  assign gnt_a = rstn && valid_a && (state == IDLE  ? (!valid_b || rr_last)
                                   : state == OWN_A ? (!valid_b || below) : (!valid_b || !below));
  assign gnt_b = rstn && valid_b && (state == IDLE  ? (!valid_a || !rr_last)
                                   : state == OWN_B ? (!valid_a || below) : (!valid_a || !below));
  assign gnt       = gnt_a || gnt_b;
  assign stay      = (gnt_a && state == OWN_A) || (gnt_b && state == OWN_B);
  assign ready_a   = gnt_a;
  assign ready_b   = gnt_b;
  assign mem_en    = gnt;
  assign mem_we    = gnt_a ? op_a : gnt_b ? op_b : 1'b0;
  assign mem_addr  = gnt_a ? addr_a : gnt_b ? addr_b : '0;
  assign mem_wdata = gnt_a ? wr_data_a : gnt_b ? wr_data_b : '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      rr_last    <= 1'b1;
      tag_v      <= '0;
      tag_b      <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
    end else begin
      state     <= gnt_a ? OWN_A : gnt_b ? OWN_B : IDLE;
      burst_cnt <= !gnt ? '0 : !stay ? CW'(1) : below ? burst_cnt + 1'b1 : burst_cnt;
      if (gnt) rr_last <= gnt_b;
      // Each read drops a port tag into a delay line matching the RAM latency.
      tag_v[0] <= gnt && !mem_we;
      tag_b[0] <= gnt_b;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
      end
      rd_valid_a <= tag_v[RD_LAT-1] && !tag_b[RD_LAT-1];
      rd_valid_b <= tag_v[RD_LAT-1] && tag_b[RD_LAT-1];
      if (tag_v[RD_LAT-1] && !tag_b[RD_LAT-1]) rd_data_a <= mem_rdata;
      if (tag_v[RD_LAT-1] && tag_b[RD_LAT-1]) rd_data_b <= mem_rdata;
    end
  end
`ifdef DP_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_cnt_a  <= '0;
      grant_cnt_b  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_a && ~&grant_cnt_a) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (gnt_b && ~&grant_cnt_b) grant_cnt_b <= grant_cnt_b + 16'd1;
      if (valid_a && valid_b && ~&conflict_cnt) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dp_mem_port_arbiter.sv
// tb_dp_mem_port_arbiter: two arbiters (RD_LAT 1 and 2) on shared stimulus, checked against a transaction-level model.
module tb_dp_mem_port_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic va, vb, oa, ob;
  logic [7:0] aa, ab;
  logic [31:0] da, db;
  logic [1:0] ra, rb, rva, rvb, men, mwe;
  logic [7:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];
  logic [31:0] rda [2];
  logic [31:0] rdb [2];
`ifdef DP_ARB_STATS_EN
  logic [15:0] gca [2];
  logic [15:0] gcb [2];
  logic [15:0] cnf [2];
`endif
  for (genvar g = 0; g < 2; g++) begin : d
    localparam int L = g + 1;
    logic [31:0] ram [256];
    logic [31:0] pipe [L];
    dp_mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(MB), .RD_LAT(L)) u (
      .clk(clk), .rstn(rstn), .valid_a(va), .valid_b(vb), .ready_a(ra[g]), .ready_b(rb[g]),
      .op_a(oa), .op_b(ob), .addr_a(aa), .addr_b(ab), .wr_data_a(da), .wr_data_b(db),
      .rd_data_a(rda[g]), .rd_data_b(rdb[g]), .rd_valid_a(rva[g]), .rd_valid_b(rvb[g]),
      .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]), .mem_wdata(mwd[g]), .mem_rdata(mrd[g])
`ifdef DP_ARB_STATS_EN
      , .grant_cnt_a(gca[g]), .grant_cnt_b(gcb[g]), .conflict_cnt(cnf[g])
`endif
    );
    initial for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    always @(posedge clk) begin
      if (men[g] && !mwe[g]) pipe[0] <= ram[maddr[g]];
      if (men[g] && mwe[g]) ram[maddr[g]] <= mwd[g];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd[g] = pipe[L-1];
  end
  typedef struct {int due; int port; logic [31:0] data;} rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];
  logic [31:0] ref_mem [256];
  int owner = 0, run = 0, last = 2, cyc = 0, cur_g = 0;
  int n_cmp = 0, n_err = 0;
  logic e_rva [2];
  logic e_rvb [2];
  logic [31:0] e_rda [2];
  logic [31:0] e_rdb [2];
  logic s_ra, s_rb, s_we;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 60) $display("FAIL %s t=%0t got %h expected %h", n, $time, act, exp);
    end
  endtask
  // Contention: the owner runs until MB grants, then the other side; from idle, alternate.
  function automatic int pick();
    if (!rstn) return 0;
    if (va && vb) return owner == 0 ? (last == 1 ? 2 : 1) : (run < MB ? owner : 3 - owner);
    return va ? 1 : vb ? 2 : 0;
  endfunction
  task automatic model_reset();
    owner = 0; run = 0; last = 2;
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin
      e_rva[i] = 1'b0; e_rvb[i] = 1'b0; e_rda[i] = 32'h0; e_rdb[i] = 32'h0;
    end
  endtask
  task automatic step(input logic a_v, b_v, a_op, b_op, input logic [7:0] a_ad, b_ad,
                      input logic [31:0] a_d, b_d);
    rsp_t r;
    logic [7:0] ad;
    va = a_v; vb = b_v; oa = a_op; ob = b_op; aa = a_ad; ab = b_ad; da = a_d; db = b_d;
    @(negedge clk);
    cur_g = pick();
    s_ra = ra[0]; s_rb = rb[0]; s_we = mwe[0];
    for (int i = 0; i < 2; i++) begin
      chk("ready_a", ra[i], cur_g == 1);
      chk("ready_b", rb[i], cur_g == 2);
      chk("mem_en", men[i], cur_g != 0);
      chk("mem_we", mwe[i], cur_g == 1 ? oa : cur_g == 2 ? ob : 1'b0);
      chk("mem_addr", maddr[i], cur_g == 1 ? aa : cur_g == 2 ? ab : 8'h0);
      chk("mem_wdata", mwd[i], cur_g == 1 ? da : cur_g == 2 ? db : 32'h0);
      chk("rd_valid_a", rva[i], e_rva[i]);
      chk("rd_valid_b", rvb[i], e_rvb[i]);
      chk("rd_data_a", rda[i], e_rda[i]);
      chk("rd_data_b", rdb[i], e_rdb[i]);
    end
    @(posedge clk);
    cyc++;
    if (!rstn) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin e_rva[i] = 1'b0; e_rvb[i] = 1'b0; end
      if (q0.size() > 0 && q0[0].due == cyc) begin
        r = q0.pop_front();
        if (r.port == 1) begin e_rva[0] = 1'b1; e_rda[0] = r.data; end
        else begin e_rvb[0] = 1'b1; e_rdb[0] = r.data; end
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        r = q1.pop_front();
        if (r.port == 1) begin e_rva[1] = 1'b1; e_rda[1] = r.data; end
        else begin e_rvb[1] = 1'b1; e_rdb[1] = r.data; end
      end
      if (cur_g != 0) begin
        ad = cur_g == 1 ? aa : ab;
        if ((cur_g == 1 ? oa : ob)) ref_mem[ad] = cur_g == 1 ? da : db;
        else begin
          q0.push_back('{cyc + 1, cur_g, ref_mem[ad]});
          q1.push_back('{cyc + 2, cur_g, ref_mem[ad]});
        end
        run = cur_g == owner ? (run < MB ? run + 1 : run) : 1;
        owner = cur_g; last = cur_g;
      end else begin
        owner = 0; run = 0;
      end
    end
    #1;
  endtask
  typedef struct {logic va, vb, oa, ob; logic [7:0] aa, ab; logic [31:0] da, db; logic era, erb;} vec_t;
  vec_t tbl [36];
  logic pv_a, pv_b, po_a, po_b;
  logic [7:0] pa_a, pa_b;
  logic [31:0] pd_a, pd_b;
  int na;
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    va = 0; vb = 0; oa = 0; ob = 0; aa = 0; ab = 0; da = 0; db = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    for (int i = 0; i < 36; i++) begin
      tbl[i] = '{va: i >= 10 && i < 26, vb: i >= 10, oa: 1'b0, ob: 1'b0,
                 aa: 8'(i), ab: 8'(i + 64), da: 32'h0, db: 32'h0, era: 1'b0, erb: i >= 26};
      if (i >= 10 && i < 26) begin
        tbl[i].era = ((i - 10) / MB) % 2 == 0;
        tbl[i].erb = !tbl[i].era;
      end
    end
    na = 0;
    foreach (tbl[i]) begin
      step(tbl[i].va, tbl[i].vb, tbl[i].oa, tbl[i].ob, tbl[i].aa, tbl[i].ab, tbl[i].da, tbl[i].db);
      chk("tbl_ready_a", s_ra, tbl[i].era);
      chk("tbl_ready_b", s_rb, tbl[i].erb);
      if (i >= 10 && i < 26 && s_ra) na++;
    end
    chk("burst_a_count", na, 8);
    step(1, 0, 1, 0, 8'h10, 0, 32'hDEADBEEF, 0);
    chk("raw_we_write", s_we, 1);
    step(0, 1, 0, 0, 0, 8'h10, 0, 0);
    chk("raw_we_read", s_we, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_rd_valid_b", rvb[0], 1);
    chk("raw_rd_data_b", rdb[0], 32'hDEADBEEF);
    chk("raw_rd_valid_a", rva[0], 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 8'h20, 0, 0, 0);
    rstn = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_drop_a", rva[1], 0);
    end
    step(1, 1, 0, 0, 8'h21, 8'h22, 0, 0);
    chk("rst_tie_a", s_ra, 1);
    chk("rst_tie_b", s_rb, 0);
    pv_a = 0; pv_b = 0; po_a = 0; po_b = 0; pa_a = 0; pa_b = 0; pd_a = 0; pd_b = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pv_a && $urandom_range(2) != 0) begin
        pv_a = 1; po_a = 1'($urandom_range(1)); pa_a = 8'($urandom_range(15)); pd_a = $urandom;
      end
      if (!pv_b && $urandom_range(2) != 0) begin
        pv_b = 1; po_b = 1'($urandom_range(1)); pa_b = 8'($urandom_range(15)); pd_b = $urandom;
      end
      rstn = $urandom_range(63) != 0;
      step(pv_a, pv_b, po_a, po_b, pa_a, pa_b, pd_a, pd_b);
      if (cur_g == 1) pv_a = 0;
      if (cur_g == 2) pv_b = 0;
    end
    rstn = 1'b1;
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DP_ARB_STATS_EN
    rstn = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    repeat (6) step(1, 1, 0, 1, 8'h30, 8'h31, 0, 32'h5);
    repeat (3) step(1, 0, 0, 0, 8'h32, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("stat_conflict", cnf[i], 6);
      chk("stat_grant_a", gca[i], 7);
      chk("stat_grant_b", gcb[i], 2);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
